// File: rtl/cpu_pkg.sv
// Shared CPU definitions: next-PC select codes used by decoder and fetch,
// fetch FSM encoding and the default reset vector.
package cpu_pkg;

    localparam logic [2:0] PC_SEQ    = 3'b000;
    localparam logic [2:0] PC_JUMP   = 3'b001;
    localparam logic [2:0] PC_JREG   = 3'b010;
    localparam logic [2:0] PC_BRANCH = 3'b011;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/npc_calc.sv
// Combinational next-PC selection for the fetch stage, plus detection of a
// register jump whose target is not word aligned.
module npc_calc
    import cpu_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] instr,
    input  logic [2:0]  pc_control,
    input  logic [31:0] jr_target,
    output logic [31:0] pc_plus4,
    output logic [31:0] next_pc,
    output logic        jr_misalign
);

    logic [31:0] branch_off;

    assign pc_plus4   = pc + 32'd4;
    assign branch_off = {{14{instr[15]}}, instr[15:0], 2'b00};

    // NOTE: next_pc gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        next_pc     = pc_plus4;
        jr_misalign = 1'b0;
        case (pc_control)
            PC_JUMP:   next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
            PC_JREG: begin
                next_pc     = {jr_target[31:2], 2'b00};
                jr_misalign = |jr_target[1:0];
            end
            PC_BRANCH: next_pc = pc_plus4 + branch_off;
            default:   next_pc = pc_plus4;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one instruction in flight, fetched over a
// req/ready handshake and presented to the decoder for one execute cycle.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ready,
    input  logic [31:0]      imem_rdata,
    input  logic             exec_hold,
    input  logic [2:0]       pc_control,
    input  logic [31:0]      jr_target,
    output logic [31:0]      instr,
    output logic             instr_valid,
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus4,
    output logic             misalign,
    output logic [CNT_W-1:0] retired
);

    fetch_state_t state, state_nxt;
    logic [31:0]  next_pc;
    logic         jr_misalign;
    logic         fetch_done;
    logic         exec_done;

    npc_calc u_npc_calc (
        .pc          (pc),
        .instr       (instr),
        .pc_control  (pc_control),
        .jr_target   (jr_target),
        .pc_plus4    (pc_plus4),
        .next_pc     (next_pc),
        .jr_misalign (jr_misalign)
    );

    // imem_ready only counts while a request is outstanding.
    assign fetch_done = (state == ST_FETCH) && imem_ready;
    assign exec_done  = (state == ST_EXEC) && !exec_hold;

    always_comb begin
        state_nxt   = state;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        case (state)
            ST_BOOT:  state_nxt = ST_FETCH;
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) state_nxt = ST_EXEC;
            end
            ST_EXEC: begin
                instr_valid = 1'b1;
                if (!exec_hold) state_nxt = ST_FETCH;
            end
            default:  state_nxt = ST_BOOT;
        endcase
    end

    assign imem_addr = pc;

    // NOTE: all state registers use non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_BOOT;
            pc       <= RESET_PC;
            instr    <= 32'h0;
            misalign <= 1'b0;
            retired  <= '0;
        end else begin
            state <= state_nxt;
            if (fetch_done) instr <= imem_rdata;
            if (exec_done) begin
                pc      <= next_pc;
                retired <= retired + CNT_W'(1);
                if (jr_misalign) misalign <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed sequences, a next-PC vector
// table and randomized traffic against a transaction-level reference model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        exec_hold = 1'b0;
    logic [2:0]  pc_control = 3'b000;
    logic [31:0] jr_target = 32'h0;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        misalign;
    logic [31:0] retired;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: architectural PC, retired count and sticky flag.
    logic [31:0] m_pc;
    logic [31:0] m_ret;
    logic        m_mis;

    fetch_unit #(.RESET_PC(32'h0), .CNT_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .exec_hold   (exec_hold),
        .pc_control  (pc_control),
        .jr_target   (jr_target),
        .instr       (instr),
        .instr_valid (instr_valid),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .misalign    (misalign),
        .retired     (retired)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [31:0] word,
                                               input logic [2:0] ctl, input logic [31:0] jr);
        int imm;
        case (ctl)
            3'd1: return ((cur + 32'd4) & 32'hF000_0000) | ((word & 32'h03FF_FFFF) << 2);
            3'd2: return jr & 32'hFFFF_FFFC;
            3'd3: begin
                imm = int'(word & 32'h0000_FFFF);
                if (imm >= 32768) imm = imm - 65536;
                return cur + 32'd4 + 32'(imm * 4);
            end
            default: return cur + 32'd4;
        endcase
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        imem_ready = 1'b0;
        exec_hold = 1'b0;
        pc_control = 3'b000;
        step();
        step();
        check("rst_pc", pc, 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_valid", {31'h0, instr_valid}, 32'h0);
        check("rst_req", {31'h0, imem_req}, 32'h0);
        check("rst_misalign", {31'h0, misalign}, 32'h0);
        check("rst_retired", retired, 32'h0);
        rst = 1'b0;
        m_pc = 32'h0;
        m_ret = 32'h0;
        m_mis = 1'b0;
    endtask

    // One full instruction: optional memory wait, fetch, optional hold, retire.
    task automatic fetch_exec(input logic [31:0] word, input logic [2:0] ctl,
                              input logic [31:0] jr, input int delay, input int hold);
        int waited = 0;
        while (!imem_req && waited < 5) begin
            step();
            waited++;
        end
        check("req_seen", {31'h0, imem_req}, 32'h1);
        check("fetch_addr", imem_addr, m_pc);
        for (int d = 0; d < delay; d++) begin
            imem_ready = 1'b0;
            imem_rdata = $urandom;
            step();
            check("req_held", {31'h0, imem_req}, 32'h1);
            check("wait_valid", {31'h0, instr_valid}, 32'h0);
        end
        imem_ready = 1'b1;
        imem_rdata = word;
        step();
        imem_ready = 1'b0;
        imem_rdata = $urandom;
        check("exec_valid", {31'h0, instr_valid}, 32'h1);
        check("exec_req", {31'h0, imem_req}, 32'h0);
        check("exec_instr", instr, word);
        check("exec_pc", pc, m_pc);
        check("exec_pc4", pc_plus4, m_pc + 32'd4);
        for (int h = 0; h < hold; h++) begin
            exec_hold = 1'b1;
            pc_control = ~ctl;
            jr_target = $urandom | 32'h1;
            step();
            check("hold_valid", {31'h0, instr_valid}, 32'h1);
            check("hold_pc", pc, m_pc);
            check("hold_retired", retired, m_ret);
            check("hold_instr", instr, word);
        end
        exec_hold = 1'b0;
        pc_control = ctl;
        jr_target = jr;
        if (ctl == 3'd2 && jr[1:0] != 2'b00) m_mis = 1'b1;
        m_pc = model_next(m_pc, word, ctl, jr);
        m_ret = m_ret + 32'd1;
        step();
        check("post_valid", {31'h0, instr_valid}, 32'h0);
        check("post_retired", retired, m_ret);
        check("post_misalign", {31'h0, misalign}, {31'h0, m_mis});
        check("post_addr", imem_addr, m_pc);
    endtask

    typedef struct {
        logic [31:0] setup_pc;
        logic [31:0] word;
        logic [2:0]  ctl;
        logic [31:0] jr;
        logic [31:0] exp_pc;
        logic        exp_mis;
    } npc_vec_t;

    npc_vec_t vecs[9];

    initial begin
        vecs[0] = '{32'h0040_0010, 32'h0810_0004, 3'b001, 32'h0,         32'h0040_0010, 1'b0};
        vecs[1] = '{32'h0000_0100, 32'h0000_FFFF, 3'b011, 32'h0,         32'h0000_0100, 1'b0};
        vecs[2] = '{32'h0000_0100, 32'h0000_FFFF, 3'b000, 32'h0,         32'h0000_0104, 1'b0};
        vecs[3] = '{32'h0000_0000, 32'h0000_0000, 3'b010, 32'h0000_2003, 32'h0000_2000, 1'b1};
        vecs[4] = '{32'hFFFF_FFFC, 32'h0000_0000, 3'b000, 32'h0,         32'h0000_0000, 1'b0};
        vecs[5] = '{32'h0000_0008, 32'h0000_FFF0, 3'b011, 32'h0,         32'hFFFF_FFCC, 1'b0};
        vecs[6] = '{32'h0000_0200, 32'h0000_0000, 3'b111, 32'h0000_0003, 32'h0000_0204, 1'b0};
        vecs[7] = '{32'hF000_0000, 32'h0BFF_FFFF, 3'b001, 32'h0,         32'hFFFF_FFFC, 1'b0};
        vecs[8] = '{32'h0000_1000, 32'h0000_7FFF, 3'b011, 32'h0,         32'h0002_1000, 1'b0};

        // Sequential fetch with memory always ready: 2 cycles per instruction.
        do_reset();
        imem_ready = 1'b1;
        pc_control = 3'b000;
        for (int k = 1; k <= 7; k++) begin
            imem_rdata = 32'h1000_0000 + k;
            step();
            check("seq_valid", {31'h0, instr_valid}, (k % 2 == 0) ? 32'h1 : 32'h0);
            if (k % 2 == 1) check("seq_addr", imem_addr, 32'((k - 1) * 2));
        end
        check("seq_retired", retired, 32'd3);
        imem_ready = 1'b0;

        // Next-PC vector table.
        foreach (vecs[i]) begin
            do_reset();
            fetch_exec(32'h0, 3'b010, vecs[i].setup_pc, 0, 0);
            fetch_exec(vecs[i].word, vecs[i].ctl, vecs[i].jr, 0, 0);
            check("vec_next_pc", imem_addr, vecs[i].exp_pc);
            check("vec_misalign", {31'h0, misalign}, {31'h0, vecs[i].exp_mis});
            if (vecs[i].exp_mis) begin
                fetch_exec(32'h0, 3'b000, 32'h0, 1, 0);
                fetch_exec(32'h0, 3'b000, 32'h0, 0, 1);
            end
        end

        // Memory waits 5 cycles, then decoder stalls for 3 cycles.
        do_reset();
        fetch_exec(32'h0000_0000, 3'b000, 32'h0, 5, 3);
        check("stall_retired", retired, 32'd1);
        check("stall_pc", pc, 32'h4);

        // Reset mid-FETCH, then a stray ready pulse during BOOT.
        fetch_exec(32'h0, 3'b010, 32'h0000_0800, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_req", {31'h0, imem_req}, 32'h0);
        check("midrst_pc", pc, 32'h0);
        check("midrst_valid", {31'h0, instr_valid}, 32'h0);
        step();
        rst = 1'b0;
        m_pc = 32'h0;
        m_ret = 32'h0;
        m_mis = 1'b0;
        imem_ready = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        step();
        imem_ready = 1'b0;
        check("boot_pulse_valid", {31'h0, instr_valid}, 32'h0);
        check("boot_pulse_req", {31'h0, imem_req}, 32'h1);
        check("boot_pulse_addr", imem_addr, 32'h0);
        check("boot_pulse_instr", instr, 32'h0);
        fetch_exec(32'h0000_0040, 3'b011, 32'h0, 0, 0);

        // Randomized traffic against the reference model.
        do_reset();
        for (int n = 0; n < 300; n++) begin
            logic [31:0] w;
            logic [2:0]  c;
            w = $urandom;
            c = 3'($urandom_range(0, 7));
            fetch_exec(w, c, $urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
